current_switch_ramp_ctrl: RTL and testbench
===========================================

// Module: current_switch_ramp_ctrl
// PURPOSE
// Upstream control stage for current_switch_array: accepts a target switch count
// over a valid/ready handshake and drives the N_ARRAY-bit thermometer ctrl vector.
// Walks ctrl one switch per STEP_CYCLES clocks toward the target, which limits
// output current steps. Synthesizable; runs on the msdsl emulation clock.
// PARAMETERS
// N_ARRAY      47                   number of current switches (ctrl width)
// CODE_W       $clog2(N_ARRAY+1)    width of code_in / level
// STEP_CYCLES  10                   clocks per one-switch step; legal range 1..65535
// RESET_LEVEL  N_ARRAY              switch count loaded at reset (all on)
// PORTS
// clk         in   1        emulation clock (`CLK_MSDSL)
// rst         in   1        asynchronous reset, active-high
// code_in     in   CODE_W   target number of switches on
// code_valid  in   1        code_in valid
// code_ready  out  1        block accepts code_in this cycle
// ctrl        out  N_ARRAY  thermometer: ctrl[i] = (i < level)
// level       out  CODE_W   current number of switches on
// busy        out  1        ramp in progress
// err_range   out  1        one-cycle pulse: accepted code_in > N_ARRAY (clamped)
// BEHAVIOUR
// - Reset (async): state=IDLE, level=RESET_LEVEL, target=RESET_LEVEL, tmr=0,
//   ctrl=therm(RESET_LEVEL), busy=0, err_range=0, code_ready=1.
// - Handshake: accept on the clk edge where code_valid && code_ready.
//   code_ready = (state==IDLE), combinational from state only.
//   code_valid while busy is ignored (not queued).
// - On accept: target <= min(code_in, N_ARRAY); err_range <= (code_in > N_ARRAY).
//   err_range is deasserted on every other cycle.
//   If the clamped target == level: remain IDLE; ctrl unchanged.
//   Otherwise: go to RAMP with tmr <= STEP_CYCLES-1.
// - RAMP: if tmr != 0, tmr decrements. If tmr == 0, level moves 1 toward target
//   and tmr reloads to STEP_CYCLES-1. When the new level equals target, go to IDLE.
// - Latency: first ctrl change occurs STEP_CYCLES clocks after the accept edge.
//   A ramp of d steps completes d*STEP_CYCLES clocks after accept.
//   code_ready rises in the same cycle as the final level update.
// - STEP_CYCLES=1: one step per clock; tmr is constant 0.
// - ctrl and level are registered and update on the same edge; ctrl never holds
//   a non-thermometer pattern. Level changes by at most 1 per edge.
// - busy = (state==RAMP), registered with the state.
// - Boundaries:
//   - code_in=0 ramps down to all-off.
//   - code_in=N_ARRAY is legal (all on).
//   - Any code_in > N_ARRAY asserts err_range and clamps to N_ARRAY.
//   - Level never wraps below 0 or above N_ARRAY.
// - rst mid-ramp: immediate return to reset values; any pending target is lost.
// STRUCTURE
// - Package current_switch_pkg:
//   - typedef enum logic {IDLE, RAMP} ramp_state_t;
//   - localparam N_ARRAY_DEF=47;
//   - function therm(level) returning the thermometer vector.
// - Sub-module therm_decoder #(N_ARRAY,CODE_W): combinational level -> ctrl,
//   with its output registered in this module.
// - Internal registers: state, level, target, tmr
//   (width $clog2(STEP_CYCLES), minimum 1 bit).
// TESTING
// 1. Reset, no input -> ctrl=47'h7FFF_FFFF_FFFF, level=47, code_ready=1, busy=0.
// 2. Accept code 44 from 47, STEP_CYCLES=10 -> level 46/45/44 at +10/+20/+30 clks;
//    busy low and code_ready high at +30.
// 3. Accept code 60 from level 10 -> err_range pulses once; ramps to 47;
//    finish at +370 clks.
// 4. While busy, present code_valid=1 with code 0 -> ignored, target unchanged.
//    After completion, code 0 ramps down to ctrl=0.
// 5. Accept code equal to level (e.g. 47 after reset) -> no busy, no ctrl change,
//    code_ready stays 1.
// 6. Assert rst mid-ramp at level 30 -> same-cycle level=47, IDLE; ctrl all ones.
//    Every cycle, check ctrl == therm(level) and |level delta| <= 1.

Source files
------------

// File: rtl/current_switch_ramp_ctrl_pkg.sv
// Shared types, defaults and helpers for the current-switch ramp controller.
package current_switch_pkg;

   typedef enum logic {IDLE = 1'b0, RAMP = 1'b1} ramp_state_t;

   localparam int unsigned N_ARRAY_DEF = 47;
   localparam int unsigned CODE_W_DEF  = $clog2(N_ARRAY_DEF + 1);

   // Thermometer vector for the default array width: bit i set when i < lvl.
   function automatic logic [N_ARRAY_DEF-1:0] therm(input logic [CODE_W_DEF-1:0] lvl);
      logic [N_ARRAY_DEF-1:0] v;
      v = '0;
      for (int unsigned i = 0; i < N_ARRAY_DEF; i++) begin
         v[i] = (CODE_W_DEF'(i) < lvl);
      end
      return v;
   endfunction

endpackage

// File: rtl/current_switch_ramp_ctrl_if.sv
// Code handshake and switch-array control bundle.
interface current_switch_ramp_ctrl_if #(
   parameter int unsigned N_ARRAY = 47,
   parameter int unsigned CODE_W  = $clog2(N_ARRAY + 1)
);
   logic [CODE_W-1:0]  code_in;
   logic               code_valid;
   logic               code_ready;
   logic [N_ARRAY-1:0] ctrl;
   logic [CODE_W-1:0]  level;
   logic               busy;
   logic               err_range;

   modport master (
      output code_in, code_valid,
      input  code_ready, ctrl, level, busy, err_range
   );

   modport slave (
      input  code_in, code_valid,
      output code_ready, ctrl, level, busy, err_range
   );
endinterface

// File: rtl/current_switch_ramp_ctrl_therm_decoder.sv
// Combinational level-to-thermometer decoder; the caller registers the result.
module therm_decoder #(
   parameter int unsigned N_ARRAY = 47,
   parameter int unsigned CODE_W  = $clog2(N_ARRAY + 1)
) (
   input  logic [CODE_W-1:0]  level_i,
   output logic [N_ARRAY-1:0] ctrl_c_o
);

   // Bit i is on when fewer than level_i switches sit below it.
   always_comb begin
      ctrl_c_o = '0;
      for (int unsigned i = 0; i < N_ARRAY; i++) begin
         ctrl_c_o[i] = (CODE_W'(i) < level_i);
      end
   end

endmodule

// File: rtl/current_switch_ramp_ctrl.sv
// Accepts a target switch count and walks the thermometer ctrl vector toward it,
// one switch per STEP_CYCLES clocks, to bound current steps at the array.
module current_switch_ramp_ctrl
   import current_switch_pkg::*;
#(
   parameter int unsigned N_ARRAY     = N_ARRAY_DEF,
   parameter int unsigned CODE_W      = $clog2(N_ARRAY + 1),
   parameter int unsigned STEP_CYCLES = 10,
   parameter int unsigned RESET_LEVEL = N_ARRAY
) (
   input  logic clk,
   input  logic rst,
   current_switch_ramp_ctrl_if.slave bus_if
);

   localparam int unsigned TMR_W = (STEP_CYCLES > 1) ? $clog2(STEP_CYCLES) : 1;
   localparam logic [TMR_W-1:0]   TMR_RELOAD = TMR_W'(STEP_CYCLES - 1);
   localparam logic [CODE_W-1:0]  LVL_MAX    = CODE_W'(N_ARRAY);
   localparam logic [CODE_W-1:0]  LVL_RESET  = CODE_W'(RESET_LEVEL);
   localparam logic [N_ARRAY-1:0] CTRL_RESET = {N_ARRAY{1'b1}} >> (N_ARRAY - RESET_LEVEL);

   localparam logic [0:0] ST_IDLE = 1'(IDLE);
   localparam logic [0:0] ST_RAMP = 1'(RAMP);

   logic [0:0]         state_q,  state_d;
   logic [CODE_W-1:0]  level_q,  level_d;
   logic [CODE_W-1:0]  target_q, target_d;
   logic [TMR_W-1:0]   tmr_q,    tmr_d;
   logic               err_q,    err_d;
   logic               busy_q;
   logic [N_ARRAY-1:0] ctrl_q;
   logic [N_ARRAY-1:0] ctrl_next_c;
   logic [CODE_W-1:0]  code_clamped_c;
   logic               code_over_c;

   // Decode the next level so ctrl and level land on the same edge.
   therm_decoder #(
      .N_ARRAY (N_ARRAY),
      .CODE_W  (CODE_W)
   ) u_therm (
      .level_i  (level_d),
      .ctrl_c_o (ctrl_next_c)
   );

   // Range-check and clamp the incoming code.
   always_comb begin
      code_over_c    = (bus_if.code_in > LVL_MAX);
      code_clamped_c = code_over_c ? LVL_MAX : bus_if.code_in;
   end

   // Next-state: accept in IDLE, step one switch per timer expiry in RAMP.
   always_comb begin
      state_d  = state_q;
      level_d  = level_q;
      target_d = target_q;
      tmr_d    = tmr_q;
      err_d    = 1'b0;
      unique case (state_q)
         ST_IDLE: begin
            if (bus_if.code_valid) begin
               target_d = code_clamped_c;
               err_d    = code_over_c;
               if (code_clamped_c != level_q) begin
                  state_d = ST_RAMP;
                  tmr_d   = TMR_RELOAD;
               end
            end
         end
         ST_RAMP: begin
            if (tmr_q != '0) begin
               tmr_d = tmr_q - TMR_W'(1);
            end else begin
               tmr_d   = TMR_RELOAD;
               level_d = (target_q > level_q) ? level_q + CODE_W'(1)
                                              : level_q - CODE_W'(1);
               if (level_d == target_q) begin
                  state_d = ST_IDLE;
               end
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // State, datapath and output registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= ST_IDLE;
         level_q  <= LVL_RESET;
         target_q <= LVL_RESET;
         tmr_q    <= '0;
         err_q    <= 1'b0;
         busy_q   <= 1'b0;
         ctrl_q   <= CTRL_RESET;
      end else begin
         state_q  <= state_d;
         level_q  <= level_d;
         target_q <= target_d;
         tmr_q    <= tmr_d;
         err_q    <= err_d;
         busy_q   <= (state_d == ST_RAMP);
         ctrl_q   <= ctrl_next_c;
      end
   end

   // Ready is decoded straight from state so upstream sees it without delay.
   always_comb begin
      bus_if.code_ready = (state_q == ST_IDLE);
      bus_if.ctrl       = ctrl_q;
      bus_if.level      = level_q;
      bus_if.busy       = busy_q;
      bus_if.err_range  = err_q;
   end

endmodule

// File: tb/tb_current_switch_ramp_ctrl.sv
// Bench for current_switch_ramp_ctrl: directed scenarios plus random traffic,
// checked every cycle against a closed-form ramp model.
module tb_current_switch_ramp_ctrl;

   localparam int unsigned N    = 47;
   localparam int unsigned CW   = $clog2(N + 1);
   localparam int unsigned STEP = 10;

   logic clk = 1'b0;
   logic rst = 1'b1;

   current_switch_ramp_ctrl_if #(.N_ARRAY(N), .CODE_W(CW)) bus_if ();

   current_switch_ramp_ctrl #(
      .N_ARRAY     (N),
      .CODE_W      (CW),
      .STEP_CYCLES (STEP),
      .RESET_LEVEL (N)
   ) dut (
      .clk    (clk),
      .rst    (rst),
      .bus_if (bus_if)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   // Model: ramp from m_start to m_tgt, m_t clocks since the accept edge.
   int m_start, m_tgt, m_t;
   bit m_err;
   int prev_lvl;

   function automatic int m_level();
      int d, k;
      d = (m_tgt >= m_start) ? m_tgt - m_start : m_start - m_tgt;
      k = m_t / STEP;
      if (k > d) k = d;
      return (m_tgt >= m_start) ? m_start + k : m_start - k;
   endfunction

   function automatic bit m_idle();
      return m_level() == m_tgt;
   endfunction

   task automatic model_reset();
      m_start = N;
      m_tgt   = N;
      m_t     = 0;
      m_err   = 1'b0;
   endtask

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   task automatic check_outputs(input bit skip_delta);
      int lvl;
      int obs_lvl;
      int dl;
      logic [63:0] exp_ctrl;
      lvl      = m_level();
      exp_ctrl = (64'd1 << lvl) - 64'd1;
      obs_lvl  = int'(bus_if.level);
      check("level", 64'(bus_if.level), 64'(lvl));
      check("ctrl",  64'(bus_if.ctrl),  exp_ctrl);
      check("ready", 64'(bus_if.code_ready), 64'(m_idle()));
      check("busy",  64'(bus_if.busy),  64'(!m_idle()));
      check("err",   64'(bus_if.err_range), 64'(m_err));
      if (!skip_delta) begin
         dl = obs_lvl - prev_lvl;
         if (dl < 0) dl = -dl;
         check("delta", 64'(dl <= 1), 64'd1);
      end
      prev_lvl = obs_lvl;
   endtask

   // One clock: advance the model with the inputs present at the edge, then check.
   task automatic step();
      bit idle_b;
      int lvl_b;
      int code;
      idle_b = m_idle();
      lvl_b  = m_level();
      @(posedge clk);
      if (rst) begin
         model_reset();
      end else begin
         m_t++;
         m_err = 1'b0;
         if (bus_if.code_valid && idle_b) begin
            code    = int'(bus_if.code_in);
            m_start = lvl_b;
            m_tgt   = (code > N) ? N : code;
            m_err   = (code > N);
            m_t     = 0;
         end
      end
      #1;
      check_outputs(1'b0);
   endtask

   task automatic run(input int n);
      for (int i = 0; i < n; i++) step();
   endtask

   task automatic run_to_idle();
      int guard;
      guard = 0;
      while (!m_idle() && guard < 2000) begin
         step();
         guard++;
      end
   endtask

   task automatic send(input int code);
      bus_if.code_in    = CW'(code);
      bus_if.code_valid = 1'b1;
      step();
      bus_if.code_valid = 1'b0;
   endtask

   // Async reset between edges; outputs must return immediately.
   task automatic mid_reset();
      #2 rst = 1'b1;
      #1;
      model_reset();
      check_outputs(1'b1);
      step();
      rst = 1'b0;
   endtask

   initial begin
      bus_if.code_in    = '0;
      bus_if.code_valid = 1'b0;
      model_reset();
      prev_lvl = N;
      #12;
      check_outputs(1'b1);
      rst = 1'b0;

      // Target equal to current level: no ramp.
      send(47);
      run(5);

      // Small downward ramp.
      send(44);
      run(35);

      // Go to 10, then out-of-range request with a code held during the ramp.
      send(10);
      run_to_idle();
      run(3);
      bus_if.code_in    = CW'(60);
      bus_if.code_valid = 1'b1;
      step();
      bus_if.code_in    = '0;
      run_to_idle();
      step();
      bus_if.code_valid = 1'b0;
      run_to_idle();
      run(3);

      // Reset in the middle of an upward ramp at level 30.
      send(47);
      run(305);
      mid_reset();
      run(3);

      // Random traffic with occasional resets.
      for (int i = 0; i < 8000; i++) begin
         bus_if.code_valid = ($urandom_range(0, 3) == 0);
         bus_if.code_in    = CW'($urandom_range(0, (1 << CW) - 1));
         if ($urandom_range(0, 799) == 0) mid_reset();
         else step();
      end
      bus_if.code_valid = 1'b0;
      run(5);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
